// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the front end; fetch_entry_t is one fetch queue entry {instr, pc}.
package riscv_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {instr,pc} queue between fetch and decode with almost-full and flush.
// Ports: clk_i/rstn_i (async active-low reset), flush_i drops all entries,
//        valid_i/instr_i/pc_i/ready_o push side, valid_o/instr_o/pc_o/ready_i pop side,
//        almost_full_o early stop for fetch, count_o occupancy.
// Macro FETCH_QUEUE_BYPASS_EN: when defined, an empty queue forwards valid_i/instr_i/pc_i
//        combinationally to decode; undefined (default) gives one-cycle latency.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              pc_i,
  output logic                     ready_o,
  output logic                     almost_full_o,
  output logic                     valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int AF_TH = DEPTH - AFULL_MARGIN;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two >= 2");
  end

  fetch_entry_t    r_mem [DEPTH];
  logic [CW-1:0]   r_rd_ptr, r_wr_ptr;
  logic            w_empty, w_full, w_fwd, w_push, w_pop;
  fetch_entry_t    w_head;

  assign w_empty = r_rd_ptr == r_wr_ptr;
  assign w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) && (r_rd_ptr[AW] != r_wr_ptr[AW]);
  assign count_o = r_wr_ptr - r_rd_ptr;
  assign ready_o = !w_full;
  // A threshold of zero or below means almost_full is permanently asserted.
  assign almost_full_o = (AF_TH <= 0) ? 1'b1 : (count_o >= CW'(AF_TH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_fwd = w_empty & valid_i & !flush_i;
`else
  assign w_fwd = 1'b0;
`endif

  // A forwarded entry that decode takes this cycle never enters the array.
  assign w_push = valid_i & ready_o & !flush_i & !(w_fwd & ready_i);
  assign w_pop  = !w_empty & ready_i & !flush_i;

  assign w_head  = w_fwd ? fetch_entry_t'{instr: instr_i, pc: pc_i} : r_mem[r_rd_ptr[AW-1:0]];
  assign valid_o = !w_empty | w_fwd;
  assign instr_o = valid_o ? w_head.instr : '0;
  assign pc_o    = valid_o ? w_head.pc : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= fetch_entry_t'{instr: instr_i, pc: pc_i};
  end

  // Simulation checks; a push offered while full is a fetch protocol slip, reported but tolerated.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      assert (count_o <= CW'(DEPTH)) else $error("fetch_queue: count exceeds DEPTH");
      assert (!(w_pop && w_empty)) else $error("fetch_queue: pop while empty");
      assert (!(valid_i && !ready_o && !flush_i)) else $warning("fetch_queue: valid_i while full, entry dropped");
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH=4, AFULL_MARGIN=2).
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;

  logic        clk_i = 0, rstn_i = 0, flush_i = 0, valid_i = 0, ready_i = 0;
  logic [31:0] instr_i = 0, pc_i = 0, instr_o, pc_o;
  logic        ready_o, almost_full_o, valid_o;
  logic [2:0]  count_o;

  int n_chk = 0, n_err = 0;
  logic [63:0] sb[$];

  fetch_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .pc_i(pc_i), .ready_o(ready_o), .almost_full_o(almost_full_o),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    valid_i = v; instr_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl;
    @(posedge clk_i); #1;
  endtask

  // Per-cycle reference: the queue holds expected entries; head is compared, then the
  // model commits what the upcoming rising edge will do.
  int          n;
  logic        byp;
  logic [63:0] exp_head;
  always @(negedge clk_i) begin
    if (!rstn_i) sb.delete();
    else begin
      n = sb.size();
      byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (n == 0) && valid_i && !flush_i;
`endif
      chk("count", 64'(count_o), 64'(n));
      chk("ready", 64'(ready_o), 64'(n < DEPTH));
      chk("afull", 64'(almost_full_o), 64'(n >= DEPTH - MARGIN));
      chk("valid", 64'(valid_o), 64'(n != 0 || byp));
      exp_head = (n != 0) ? sb[0] : byp ? {instr_i, pc_i} : 64'h0;
      chk("instr", 64'(instr_o), 64'(exp_head[63:32]));
      chk("pc", 64'(pc_o), 64'(exp_head[31:0]));
      if (flush_i) sb.delete();
      else begin
        if (n != 0 && ready_i) void'(sb.pop_front());
        if (valid_i && n < DEPTH && !(byp && ready_i)) sb.push_back({instr_i, pc_i});
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_afull", 64'(almost_full_o), 64'd0);
    chk("rst_pc", 64'(pc_o), 64'd0);
    #20 rstn_i = 1;
    @(posedge clk_i); #1;
    cyc(0, 0, 0, 0, 0);
    // single push then pop
    cyc(1, 32'h00000013, 32'h80000000, 1, 0);
    chk("t2_pc", 64'(pc_o), 64'h80000000);
    cyc(0, 0, 0, 1, 0);
    chk("t2_count", 64'(count_o), 64'd0);
    // fill to full, overflow attempt, drain
    for (int i = 0; i < 4; i++) cyc(1, 32'h13 + 32'(i), 32'h80000000 + 32'(4 * i), 0, 0);
    chk("t3_full", 64'(ready_o), 64'd0);
    cyc(1, 32'hdead, 32'h80000010, 0, 0);
    chk("t3_count", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 64'(pc_o), 64'h80000000 + 64'(4 * i));
      cyc(0, 0, 0, 1, 0);
    end
    chk("t3_empty", 64'(valid_o), 64'd0);
    // flush beats push and pop
    for (int i = 0; i < 3; i++) cyc(1, 32'h100 + 32'(i), 32'h90000000 + 32'(4 * i), 0, 0);
    cyc(1, 32'h200, 32'h9000000C, 1, 1);
    chk("t4_count", 64'(count_o), 64'd0);
    chk("t4_valid", 64'(valid_o), 64'd0);
    // sustained push+pop with wrap
    cyc(1, 32'h300, 32'hA0000000, 0, 0);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      chk("t5_count", 64'(count_o), 64'd1);
      chk("t5_pc", 64'(pc_o), 64'hA0000000 + 64'(4 * (i - 1)));
      cyc(1, 32'h300 + 32'(i), 32'hA0000000 + 32'(4 * i), 1, 0);
    end
    cyc(0, 0, 0, 1, 0);
    // async reset mid-operation
    cyc(1, 32'h400, 32'hB0000000, 0, 0);
    cyc(1, 32'h401, 32'hB0000004, 0, 0);
    valid_i = 0;
    #2 rstn_i = 0;
    #1;
    chk("rst_mid_count", 64'(count_o), 64'd0);
    chk("rst_mid_valid", 64'(valid_o), 64'd0);
    #3 rstn_i = 1;
    @(posedge clk_i); #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    valid_i = 1; instr_i = 32'h00100093; pc_i = 32'hC0000000; ready_i = 1; #1;
    chk("t6_valid", 64'(valid_o), 64'd1);
    chk("t6_instr", 64'(instr_o), 64'h00100093);
    @(posedge clk_i); #1;
    valid_i = 0;
    chk("t6_count0", 64'(count_o), 64'd0);
    cyc(1, 32'h00100093, 32'hC0000004, 0, 0);
    chk("t6_count1", 64'(count_o), 64'd1);
    cyc(0, 0, 0, 1, 0);
`endif
    cyc(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
